memoria_principal_resp: RTL
===========================

// Module: memoria_principal_resp
// PURPOSE
//  Main-memory responder on the memory side of the 2-way write-back cache interface.
//  - Accepts one request at a time from the cache controller: READ (fill), WRITE, or
//    WB_FILL (write back the dirty victim, then fill the missed block).
//  - Models a fixed access latency and returns read data with a valid/ready response handshake.
// PARAMETERS
//  ADDR_W   5  word address width; memory depth = 2**ADDR_W words
//  DATA_W   3  word width (one cache block = one word, no offset)
//  LATENCY  2  cycles per array access; legal range 1..15
// PORTS
//  clock      in   1       single clock, rising edge
//  reset_n    in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       responder idle, can accept
//  req_op     in   2       00 READ, 01 WRITE, 10 WB_FILL, 11 reserved (executed as READ)
//  req_addr   in   ADDR_W  read/fill or write address
//  req_wdata  in   DATA_W  write data (WRITE)
//  wb_addr    in   ADDR_W  victim address (WB_FILL)
//  wb_data    in   DATA_W  victim data (WB_FILL)
//  resp_valid out  1       response present
//  resp_ready in   1       cache consumes response
//  resp_rdata out  DATA_W  READ/WB_FILL: word at req_addr; WRITE: written data
//  busy       out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset (async assert): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, busy=0.
//  - Latency counter and captured request registers clear to 0.
//  - Array contents are kept across reset; at simulation start mem[i] = i mod 2**DATA_W.
//  Handshakes
//  - Request is accepted on a rising edge with req_valid && req_ready.
//  - All req_*/wb_* fields are captured at acceptance; later input changes are ignored.
//  - req_ready = (state==IDLE), decoded combinationally from the state register.
//  FSM states: IDLE, WB (victim write), ACC (main access), RESP.
//  - IDLE -> WB on accept with op=10; IDLE -> ACC on accept with any other op. Counter loads LATENCY-1.
//  - WB: when counter==0, write wb_data to wb_addr, reload counter, go to ACC; else decrement.
//  - ACC: when counter==0, perform the read or write, register resp_rdata, go to RESP; else decrement.
//  - RESP: resp_valid=1 with resp_rdata held stable; on resp_valid && resp_ready go to IDLE.
//    req_ready rises the following cycle, so there is no back-to-back accept.
//  Timing (accept at edge k)
//  - READ/WRITE: resp_valid is visible after edge k+LATENCY.
//  - WB_FILL: resp_valid is visible after edge k+2*LATENCY.
//  Boundaries
//  - WB_FILL with wb_addr==req_addr: the fill returns wb_data (the write commits first).
//  - WRITE: resp_rdata = captured req_wdata.
//  - resp_ready held high while not in RESP: ignored.
//  - resp_ready low in RESP: stall indefinitely, outputs stable.
//  - Address wrap: none; every ADDR_W value is valid.
//  - reset_n low mid-operation: abort immediately.
//    Any write whose commit edge has not occurred is discarded.
//    A victim write already committed in WB stays in the array.
//  - LATENCY=1: counter is always 0, so each access takes exactly one cycle in WB/ACC.
// CONFIGURATION
//  MEM_STATS_EN defined: adds outputs stat_rd [15:0] and stat_wr [15:0].
//  - stat_rd increments on each ACC read commit; stat_wr increments on each array write commit.
//  - A WB_FILL counts once in each counter.
//  - Both counters saturate at 16'hFFFF and reset to 0.
//  MEM_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING (LATENCY=2 unless stated)
//  1 Reset, then READ addr 5 with resp_ready=1
//    -> resp_valid rises 2 cycles after accept, resp_rdata=3'b101, busy 0 after the handshake.
//  2 WRITE addr 9 data 3'b110, then READ addr 9
//    -> first resp_rdata=3'b110; second resp_rdata=3'b110; mem[9] changed only at commit edge.
//  3 WB_FILL wb_addr=4 wb_data=3'b111, req_addr=12
//    -> resp after 4 cycles with resp_rdata=3'b100; subsequent READ addr 4 returns 3'b111.
//  4 WB_FILL wb_addr=req_addr=7, wb_data=3'b010 -> resp_rdata=3'b010.
//  5 Hold resp_ready=0 for 5 cycles in RESP
//    -> resp_valid and resp_rdata stable, req_ready=0; one cycle after the handshake req_ready=1.
//  6 Assert reset_n low 1 cycle after accepting WRITE addr 2 data 3'b000
//    -> outputs reset, mem[2] stays 3'b010.
//    With MEM_STATS_EN: after tests 1-3, stat_rd=3, stat_wr=2.

Source files
------------

// File: rtl/memoria_principal_resp.sv
// memoria_principal_resp: main-memory responder for a write-back cache with fixed access latency.
// The optional MEM_STATS_EN macro adds the stat_rd/stat_wr access counters.
module memoria_principal_resp #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 3,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_wr
`endif
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WB, ACC, RESP} state_t;
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
        return m;
    endfunction

    // Power-up contents only; the array is never touched by reset.
    mem_t mem = mem_init();

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, wb_addr_q, wb_addr_d, wa;
    logic [DATA_W-1:0]   wdata_q, wdata_d, wb_data_q, wb_data_d, rdata_q, rdata_d, wd;
    logic                we;

    assign req_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;

    // Next-state, request capture and array write-port selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        rdata_d   = rdata_q;
        we        = 1'b0;
        wa        = wb_addr_q;
        wd        = wb_data_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d      = req_op;
                addr_d    = req_addr;
                wdata_d   = req_wdata;
                wb_addr_d = wb_addr;
                wb_data_d = wb_data;
                cnt_d     = CNT_INIT;
                state_d   = req_op == 2'b10 ? WB : ACC;
            end
            WB: if (cnt_q == 4'd0) begin
                we      = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = ACC;
            end else cnt_d = cnt_q - 4'd1;
            ACC: if (cnt_q == 4'd0) begin
                we      = op_q == 2'b01;
                wa      = addr_q;
                wd      = wdata_q;
                rdata_d = op_q == 2'b01 ? wdata_q : mem[addr_q];
                state_d = RESP;
            end else cnt_d = cnt_q - 4'd1;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and captured-request registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (we) mem[wa] <= wd;
    end

`ifdef MEM_STATS_EN
    logic        rd_commit;
    logic [15:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;

    assign rd_commit = state_q == ACC && cnt_q == 4'd0 && op_q != 2'b01;
    assign stat_rd   = stat_rd_q;
    assign stat_wr   = stat_wr_q;

    // Saturating access counters.
    always_comb begin
        stat_rd_d = stat_rd_q + 16'(rd_commit && stat_rd_q != 16'hFFFF);
        stat_wr_d = stat_wr_q + 16'(we && stat_wr_q != 16'hFFFF);
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end
`endif
endmodule
